// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle CPU sequencer: walks FETCH/DECODE/EXEC/MEM/WB per instruction and
// drives datapath strobes as decodes of the current state plus the memory handshake.
module cpu_seq_ctrl (
    input  logic        clk,
    input  logic        res_n,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic [7:0]  imm_ctrl,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_src,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        wb_sel_mem,
    output logic        retire,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    logic [6:0]  opcode_r;
    logic [31:0] instr_cnt_r;
    logic [6:0]  cur_op_s;
    logic [2:0]  funct3_s;
    logic        branch_ok_s;
    logic        branch_taken_s;
    logic        unused_ir_s;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH: is_legal_op = 1'b1;
            default:                                     is_legal_op = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] imm_code(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_code = 8'h08;
            OP_BRANCH: imm_code = 8'h18;
            default:   imm_code = 8'h00;
        endcase
    endfunction

    assign unused_ir_s = ^{ir[31:15], ir[11:7]};
    assign funct3_s    = ir[14:12];
    assign state       = state_r;
    assign instr_cnt   = instr_cnt_r;

    // State, opcode latch and retire counter; reset overrides every other input
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_r     <= ST_IDLE;
            opcode_r    <= 7'd0;
            instr_cnt_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_DECODE) begin
                opcode_r <= ir[6:0];
            end else begin
                opcode_r <= opcode_r;
            end
            if (retire) begin
                instr_cnt_r <= instr_cnt_r + 32'd1;
            end else begin
                instr_cnt_r <= instr_cnt_r;
            end
        end
    end

    // Opcode in effect: ir directly while decoding, the latched copy afterwards
    always_comb begin
        cur_op_s = opcode_r;
        if (state_r == ST_DECODE) begin
            cur_op_s = ir[6:0];
        end else begin
            cur_op_s = opcode_r;
        end
    end

    // Branch condition: only BEQ and BNE are supported
    always_comb begin
        branch_ok_s    = 1'b0;
        branch_taken_s = 1'b0;
        case (funct3_s)
            3'b000: begin
                branch_ok_s    = 1'b1;
                branch_taken_s = alu_zero;
            end
            3'b001: begin
                branch_ok_s    = 1'b1;
                branch_taken_s = ~alu_zero;
            end
            default: begin
                branch_ok_s    = 1'b0;
                branch_taken_s = 1'b0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE:   next_state_s = ST_FETCH;
            ST_FETCH:  next_state_s = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: next_state_s = is_legal_op(ir[6:0]) ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
                case (opcode_r)
                    OP_LOAD, OP_STORE: next_state_s = ST_MEM;
                    OP_R, OP_IALU:     next_state_s = ST_WB;
                    default:           next_state_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (!mem_ready) begin
                    next_state_s = ST_MEM;
                end else if (opcode_r == OP_LOAD) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_WB:   next_state_s = ST_FETCH;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode; ir_write, pc_write and retire also follow mem_ready on the ack cycle
    always_comb begin
        imm_ctrl     = 8'h00;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_src = 1'b0;
        alu_src_imm  = 1'b0;
        reg_write    = 1'b0;
        wb_sel_mem   = 1'b0;
        retire       = 1'b0;
        illegal      = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            ST_DECODE: begin
                imm_ctrl = imm_code(cur_op_s);
                illegal  = ~is_legal_op(ir[6:0]);
            end
            ST_EXEC: begin
                imm_ctrl    = imm_code(cur_op_s);
                alu_src_imm = (opcode_r == OP_IALU) || (opcode_r == OP_LOAD) ||
                              (opcode_r == OP_STORE);
                if (opcode_r == OP_BRANCH) begin
                    if (branch_ok_s) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken_s;
                        retire   = 1'b1;
                    end else begin
                        illegal  = 1'b1;
                    end
                end else begin
                    pc_write = 1'b0;
                end
            end
            ST_MEM: begin
                imm_ctrl     = imm_code(cur_op_s);
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                mem_we       = (opcode_r == OP_STORE);
                if (mem_ready && (opcode_r == OP_STORE)) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end else begin
                    pc_write = 1'b0;
                    retire   = 1'b0;
                end
            end
            ST_WB: begin
                imm_ctrl   = imm_code(cur_op_s);
                reg_write  = 1'b1;
                wb_sel_mem = (opcode_r == OP_LOAD);
                pc_write   = 1'b1;
                retire     = 1'b1;
            end
            default: begin
                imm_ctrl = 8'h00;
            end
        endcase
    end

endmodule
